// File: rtl/rgb_fade_sequencer.sv
// Colour fade sequencer: ramps an internal RGB colour toward commanded targets, holds,
// and reloads PWM duty outputs only on frame_start. Define GAMMA_EN for squared-law output mapping.
module rgb_fade_sequencer #(
  parameter int unsigned TICK_DIV = 16384
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_red,
  input  logic [7:0] cmd_green,
  input  logic [7:0] cmd_blue,
  input  logic [7:0] cmd_rate,
  input  logic [7:0] cmd_hold,
  input  logic       frame_start,
  output logic [7:0] red_value,
  output logic [7:0] green_value,
  output logic [7:0] blue_value,
  output logic       value_update,
  output logic       busy
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q;
  logic            tick;
  logic [2:0][7:0] cur_q, cur_d, tgt_q, tgt_d, val_q;
  logic [7:0]      rate_q, rate_d, rcnt_q, rcnt_d, hold_q, hold_d, hcnt_q, hcnt_d;
  logic            en_q, upd_q, accept, at_tgt;

  function automatic logic [7:0] shape(input logic [7:0] v);
`ifdef GAMMA_EN
    return 8'((16'(v) * 16'(v) + 16'd255) >> 8);
`else
    return v;
`endif
  endfunction

  assign tick      = (pre_q == PW'(TICK_DIV - 1));
  // en_q keeps the handshake closed while reset is held
  assign cmd_ready = en_q && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign at_tgt    = (cur_q == tgt_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    rate_d  = rate_q;
    rcnt_d  = rcnt_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: if (accept) begin
        tgt_d   = {cmd_blue, cmd_green, cmd_red};
        rate_d  = cmd_rate;
        rcnt_d  = cmd_rate;
        hold_d  = cmd_hold;
        state_d = FADE;
      end
      FADE: begin
        if (at_tgt) begin
          hcnt_d  = hold_q;
          state_d = HOLD;
        end else if (rate_q == 8'd0) begin
          cur_d   = tgt_q;
          hcnt_d  = hold_q;
          state_d = HOLD;
        end else if (tick) begin
          if (rcnt_q == 8'd1) begin
            rcnt_d = rate_q;
            for (int c = 0; c < 3; c++) begin
              if (cur_q[c] < tgt_q[c])      cur_d[c] = cur_q[c] + 8'd1;
              else if (cur_q[c] > tgt_q[c]) cur_d[c] = cur_q[c] - 8'd1;
            end
          end else begin
            rcnt_d = rcnt_q - 8'd1;
          end
        end
      end
      HOLD: begin
        if (hcnt_q == 8'd0)  state_d = IDLE;
        else if (tick)       hcnt_d  = hcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cur_q   <= '0;
      tgt_q   <= '0;
      val_q   <= '0;
      rate_q  <= '0;
      rcnt_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      en_q    <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= tick ? '0 : pre_q + PW'(1);
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      rate_q  <= rate_d;
      rcnt_q  <= rcnt_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      en_q    <= 1'b1;
      upd_q   <= frame_start;
      // latching cur_q (not cur_d) gives the pre-step colour on a coincident step
      if (frame_start)
        val_q <= {shape(cur_q[2]), shape(cur_q[1]), shape(cur_q[0])};
    end
  end

  assign red_value    = val_q[0];
  assign green_value  = val_q[1];
  assign blue_value   = val_q[2];
  assign value_update = upd_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4: reset, stepping timing,
// jump-to-target table, held cmd_valid, frame-aligned latching and hold duration.
module tb_rgb_fade_sequencer;
  localparam int TD = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, cmd_valid, cmd_ready, frame_start, value_update, busy;
  logic [7:0] cmd_red, cmd_green, cmd_blue, cmd_rate, cmd_hold;
  logic [7:0] red_value, green_value, blue_value;

  rgb_fade_sequencer #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue),
    .cmd_rate(cmd_rate), .cmd_hold(cmd_hold), .frame_start(frame_start),
    .red_value(red_value), .green_value(green_value), .blue_value(blue_value),
    .value_update(value_update), .busy(busy)
  );

  typedef struct {
    int r, g, b;
    int er, eg, eb;
  } vec_t;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int rel   = 0;

  function automatic int fx(input int v);
`ifdef GAMMA_EN
    return (v * v + 255) >> 8;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tk();
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic send(input int r, input int g, input int b, input int rate, input int hold);
    int n;
    cmd_red = 8'(r); cmd_green = 8'(g); cmd_blue = 8'(b);
    cmd_rate = 8'(rate); cmd_hold = 8'(hold);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin tk(); n++; end
    if (!cmd_ready) chk("send_ready", 0, 1);
    tk();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 300) begin tk(); n++; end
    chk(nm, int'(busy), 0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tk();
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   prevv, nchg, tfall, k, kstep, prevr, lastc, waited, a, t1;
    int   tchg[4];

    vt[0] = '{255, 128, 0,   255, 128, 0};
    vt[1] = '{0,   0,   0,   0,   0,   0};
    vt[2] = '{17,  200, 99,  17,  200, 99};
    vt[3] = '{1,   2,   3,   1,   2,   3};
    vt[4] = '{10,  10,  10,  10,  10,  10};

    reset_n = 1'b0; cmd_valid = 1'b0; frame_start = 1'b0;
    cmd_red = '0; cmd_green = '0; cmd_blue = '0; cmd_rate = '0; cmd_hold = '0;
    tk(); tk();
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_update", int'(value_update), 0);
    chk("rst_red", int'(red_value), 0);
    reset_n = 1'b1;
    tk(); rel = cyc;
    chk("rel_ready", int'(cmd_ready), 1);

    // mid-fade reset
    send(200, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin frame_start = 1'b1; tk(); end
    frame_start = 1'b0;
    chk("t1_fading", int'(red_value > 8'd0), 1);
    reset_n = 1'b0;
    tk();
    chk("t1_rst_busy", int'(busy), 0);
    chk("t1_rst_red", int'(red_value), 0);
    chk("t1_rst_update", int'(value_update), 0);
    chk("t1_rst_ready", int'(cmd_ready), 0);
    tk();
    reset_n = 1'b1;
    tk(); rel = cyc;
    chk("t1_rel_ready", int'(cmd_ready), 1);
    frame();
    chk("t1_cur_cleared", int'(red_value), 0);
    chk("t1_update", int'(value_update), 1);

    // rate=1 stepping with a frame every cycle
    send(3, 0, 0, 1, 0);
    prevv = 0; nchg = 0; tfall = -1;
    for (int i = 0; i < 60; i++) begin
      frame_start = 1'b1;
      tk();
      if (int'(red_value) != prevv) begin
        if (nchg < 4) tchg[nchg] = cyc;
        nchg++;
        chk("t2_step_val", int'(red_value), prevv + 1);
        prevv = int'(red_value);
      end
      if (!busy && tfall < 0) tfall = cyc;
    end
    chk("t2_nsteps", nchg, 3);
    if (nchg >= 3) begin
      chk("t2_interval1", tchg[1] - tchg[0], TD);
      chk("t2_interval2", tchg[2] - tchg[1], TD);
      chk("t2_busy_fall", tfall - tchg[2], 1);
    end
    frame_start = 1'b0;
    tk();
    chk("t2_update_low", int'(value_update), 0);
    tk(); tk(); tk();
    chk("t2_red_stable", int'(red_value), fx(3));
    frame();
    chk("t2_update_pulse", int'(value_update), 1);
    tk();
    chk("t2_update_end", int'(value_update), 0);

    // jump-to-target table
    for (int i = 0; i < 5; i++) begin
      send(vt[i].r, vt[i].g, vt[i].b, 0, 0);
      wait_idle("tbl_idle");
      frame();
      chk("tbl_red", int'(red_value), fx(vt[i].er));
      chk("tbl_green", int'(green_value), fx(vt[i].eg));
      chk("tbl_blue", int'(blue_value), fx(vt[i].eb));
      chk("tbl_update", int'(value_update), 1);
    end

    // (10,10,10) -> (5,10,12) rate=2; frames paced to hit a step edge
    send(5, 10, 12, 2, 0);
    k = -1;
    for (int i = 0; i < 40 && k < 0; i++) begin
      frame_start = 1'b1;
      tk();
      if (red_value != 8'd10) k = cyc;
    end
    frame_start = 1'b0;
    if (k < 0) chk("t5_start", 0, 1);
    else begin
      chk("t5_first_red", int'(red_value), 9);
      chk("t5_first_green", int'(green_value), 10);
      chk("t5_first_blue", int'(blue_value), 11);
      kstep = k - 1; prevr = 9; lastc = k;
      while (cyc < k + 34) begin
        frame_start = (cyc + 1 >= kstep + 8);
        tk();
        if (int'(red_value) != prevr) begin prevr = int'(red_value); lastc = cyc; end
        if (cyc == kstep + 5) begin
          chk("t5_noframe_update", int'(value_update), 0);
          chk("t5_noframe_red", int'(red_value), 9);
        end
        if (cyc == kstep + 8) begin
          chk("t5_prestep_red", int'(red_value), 9);
          chk("t5_prestep_blue", int'(blue_value), 11);
        end
        if (cyc == kstep + 9) begin
          chk("t5_poststep_red", int'(red_value), 8);
          chk("t5_poststep_blue", int'(blue_value), 12);
        end
        if (cyc == k + 32) begin
          chk("t5_final_red", int'(red_value), 5);
          chk("t5_final_green", int'(green_value), 10);
          chk("t5_final_blue", int'(blue_value), 12);
          chk("t5_busy_end", int'(busy), 1);
        end
        if (cyc == k + 33) chk("t5_busy_fall", int'(busy), 0);
      end
      chk("t5_last_step", lastc, k + 32);
    end
    frame_start = 1'b0;
    wait_idle("t5_idle");

    // cmd_valid held high through a fade
    cmd_red = 8'd5; cmd_green = 8'd10; cmd_blue = 8'd14; cmd_rate = 8'd1; cmd_hold = 8'd1;
    cmd_valid = 1'b1;
    chk("t4_ready_a", int'(cmd_ready), 1);
    tk();
    chk("t4_busy_a", int'(busy), 1);
    cmd_red = 8'd50; cmd_green = 8'd60; cmd_blue = 8'd70; cmd_rate = 8'd0; cmd_hold = 8'd0;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) break;
      tk(); waited++;
    end
    chk("t4_ready_b", int'(cmd_ready), 1);
    chk("t4_idle_at_ready", int'(busy), 0);
    chk("t4_waited", int'(waited >= 8), 1);
    tk();
    cmd_valid = 1'b0;
    chk("t4_one_accept_busy", int'(busy), 1);
    chk("t4_one_accept_ready", int'(cmd_ready), 0);
    wait_idle("t4_idle");
    frame();
    chk("t4_red", int'(red_value), fx(50));
    chk("t4_green", int'(green_value), fx(60));
    chk("t4_blue", int'(blue_value), fx(70));

    // target == cur, hold=3
    send(50, 60, 70, 1, 3);
    a = cyc;
    t1 = a + 2;
    while (((t1 - rel) % TD) != TD - 1) t1++;
    while (cyc < t1 + 2 * TD + 1) begin
      tk();
      if (cyc == a + 1) chk("t6_hold_entry_busy", int'(busy), 1);
      if (cyc == t1 + 2 * TD) chk("t6_busy_last", int'(busy), 1);
    end
    chk("t6_busy_fall", int'(busy), 0);
    chk("t6_ready_back", int'(cmd_ready), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
